// File: rtl/mux_nto1_skid_if.sv
// Handshake bundle for mux_nto1_skid: input channels with select plus the registered output side.
// The master modport drives beats in and accepts them out; the slave modport is the selector.
interface mux_nto1_skid_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        select;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, select, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, select, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_nto1_skid.sv
// N-to-1 selector with a 2-entry skid buffer (main M, skid S) and a fully registered in_ready.
// Define MUX_SEL_CHECK_EN to build the sticky out-of-range select flag sel_err.
module mux_nto1_skid #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_nto1_skid_if.slave      bus,
  output logic                sel_err,
  input  logic                sel_err_clr,
  output logic [15:0]         beat_cnt
);

  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("mux_nto1_skid: NUM_IN must be within 2..16");
  end
  if (NUM_IN > (2 ** SEL_W)) begin : g_bad_sel_w
    $error("mux_nto1_skid: SEL_W too narrow for NUM_IN");
  end

  typedef enum logic [1:0] {StEmpty, StOne, StFull} buf_state_e;

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [SEL_W-1:0] m_sel_q, m_sel_d, s_sel_q, s_sel_d;
  logic             in_ready_q;
  logic [15:0]      cnt_q;
  logic [WIDTH-1:0] cap_data;
  logic             in_xfer, out_xfer;

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = (state_q != StEmpty) & bus.out_ready;

  // Out-of-range selects match no channel and therefore capture zeros.
  always_comb begin
    cap_data = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.select == SEL_W'(k)) cap_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_sel_d  = m_sel_q;
    s_data_d = s_data_q;
    s_sel_d  = s_sel_q;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          m_data_d = cap_data;
          m_sel_d  = bus.select;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          m_data_d = cap_data;
          m_sel_d  = bus.select;
        end else if (in_xfer) begin
          s_data_d = cap_data;
          s_sel_d  = bus.select;
          state_d  = StFull;
        end else if (out_xfer) begin
          state_d  = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only the drain of M can happen.
        if (out_xfer) begin
          m_data_d = s_data_q;
          m_sel_d  = s_sel_q;
          state_d  = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      m_data_q   <= '0;
      m_sel_q    <= '0;
      s_data_q   <= '0;
      s_sel_q    <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      m_data_q   <= m_data_d;
      m_sel_q    <= m_sel_d;
      s_data_q   <= s_data_d;
      s_sel_q    <= s_sel_d;
      in_ready_q <= (state_d != StFull);
      if (in_xfer) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_data  = m_data_q;
  assign bus.out_sel   = m_sel_q;
  assign beat_cnt      = cnt_q;

`ifdef MUX_SEL_CHECK_EN
  logic sel_err_q;
  logic sel_bad;
  assign sel_bad = (32'(bus.select) >= NUM_IN);

  // A new bad select wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (in_xfer && sel_bad) begin
      sel_err_q <= 1'b1;
    end else if (sel_err_clr) begin
      sel_err_q <= 1'b0;
    end
  end
  assign sel_err = sel_err_q;
`else
  logic unused_sel_err_clr;
  assign unused_sel_err_clr = sel_err_clr;
  assign sel_err            = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nto1_skid.sv
// Bench for mux_nto1_skid (WIDTH=5, NUM_IN=3, SEL_W=2): queue-based reference model plus
// directed literal expectations for streaming, back-pressure, bad select, reset and wrap.
module tb_mux_nto1_skid;
  localparam int unsigned W  = 5;
  localparam int unsigned N  = 3;
  localparam int unsigned SW = 2;
  localparam logic [N*W-1:0] CH = {5'h1C, 5'h0A, 5'h03};
`ifdef MUX_SEL_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        sel_err;
  logic        sel_err_clr;
  logic [15:0] beat_cnt;

  mux_nto1_skid_if #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) bus ();

  mux_nto1_skid #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sel_err     (sel_err),
    .sel_err_clr (sel_err_clr),
    .beat_cnt    (beat_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a FIFO of accepted beats, at most two deep.
  int          q_data[$];
  int          q_sel[$];
  bit          ready_exp;
  logic [15:0] cnt_exp;
  bit          err_exp;

  initial begin
    ready_exp = 1'b0;
    cnt_exp   = '0;
    err_exp   = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q_data.delete();
        q_sel.delete();
        ready_exp = 1'b0;
        cnt_exp   = '0;
        err_exp   = 1'b0;
      end else begin
        bit in_x, out_x;
        in_x  = bus.in_valid && ready_exp;
        out_x = (q_data.size() > 0) && bus.out_ready;
        if (out_x) begin
          void'(q_data.pop_front());
          void'(q_sel.pop_front());
        end
        if (in_x) begin
          int s;
          logic [N*W-1:0] sh;
          s  = int'(bus.select);
          sh = bus.in_data >> (s * W);
          q_data.push_back((s < N) ? int'(sh[W-1:0]) : 0);
          q_sel.push_back(s);
          cnt_exp = cnt_exp + 16'd1;
        end
        if (ChkEn) begin
          if (in_x && int'(bus.select) >= N) err_exp = 1'b1;
          else if (sel_err_clr) err_exp = 1'b0;
        end
        ready_exp = (q_data.size() < 2);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_sel", int'(bus.out_sel), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_sel_err", int'(sel_err), 0);
        check("rst_beat_cnt", int'(beat_cnt), 0);
      end else begin
        check("out_valid", int'(bus.out_valid), int'(q_data.size() > 0));
        check("in_ready", int'(bus.in_ready), int'(ready_exp));
        check("beat_cnt", int'(beat_cnt), int'(cnt_exp));
        check("sel_err", int'(sel_err), int'(err_exp));
        if (q_data.size() > 0) begin
          check("out_data", int'(bus.out_data), q_data[0]);
          check("out_sel", int'(bus.out_sel), q_sel[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int stream_exp[3] = '{3, 10, 28};

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.select   = '0;
    bus.in_data  = CH;
    bus.out_ready = 1'b1;
    sel_err_clr  = 1'b0;

    // Reset held with in_valid high.
    repeat (3) step();
    check("lit_rst_in_ready", int'(bus.in_ready), 0);
    check("lit_rst_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    step();
    check("lit_release_in_ready", int'(bus.in_ready), 1);

    // Streaming, one beat per cycle.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.select = SW'(i);
      step();
      check("lit_stream_data", int'(bus.out_data), stream_exp[i]);
    end
    check("lit_stream_cnt", int'(beat_cnt), 3);
    bus.in_valid = 1'b0;
    step();
    check("lit_stream_drained", int'(bus.out_valid), 0);

    // Back-pressure: fill M and S, third beat waits.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.select    = 2'd0;
    step();
    check("lit_bp_ready1", int'(bus.in_ready), 1);
    check("lit_bp_hold1", int'(bus.out_data), 3);
    bus.select = 2'd1;
    step();
    check("lit_bp_ready2", int'(bus.in_ready), 0);
    check("lit_bp_hold2", int'(bus.out_data), 3);
    bus.select = 2'd2;
    step();
    check("lit_bp_ready3", int'(bus.in_ready), 0);
    check("lit_bp_hold3", int'(bus.out_data), 3);
    check("lit_bp_cnt", int'(beat_cnt), 5);
    bus.out_ready = 1'b1;
    step();
    check("lit_bp_second", int'(bus.out_data), 10);
    check("lit_bp_valid2", int'(bus.out_valid), 1);
    step();
    check("lit_bp_third", int'(bus.out_data), 28);
    check("lit_bp_valid3", int'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    step();
    check("lit_bp_cnt_end", int'(beat_cnt), 6);

    // Out-of-range select with all-ones data.
    bus.in_data  = '1;
    bus.select   = 2'd3;
    bus.in_valid = 1'b1;
    step();
    check("lit_oor_data", int'(bus.out_data), 0);
    check("lit_oor_sel", int'(bus.out_sel), 3);
    check("lit_oor_err", int'(sel_err), int'(ChkEn));
    bus.in_valid = 1'b0;
    step();
    check("lit_oor_err_hold", int'(sel_err), int'(ChkEn));
    sel_err_clr = 1'b1;
    step();
    check("lit_oor_err_clr", int'(sel_err), 0);
    bus.in_valid = 1'b1;
    step();
    check("lit_oor_set_wins", int'(sel_err), int'(ChkEn));
    bus.in_valid = 1'b0;
    step();
    sel_err_clr = 1'b0;
    bus.in_data = CH;

    // Reset asserted between edges while FULL.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.select    = 2'd1;
    repeat (2) step();
    check("lit_full_ready", int'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("lit_midrst_valid", int'(bus.out_valid), 0);
    check("lit_midrst_cnt", int'(beat_cnt), 0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("lit_postrst_valid", int'(bus.out_valid), 0);
    check("lit_postrst_cnt", int'(beat_cnt), 0);

    // Counter wrap after 65536 accepted beats.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      bus.select = SW'(i % 4);
      step();
    end
    bus.in_valid = 1'b0;
    check("lit_wrap_cnt", int'(beat_cnt), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_nto1_skid.md
Name: mux_nto1_skid

Overview:
- Parametrised N-to-1 selector with a registered, flow-controlled output.
- Successor to the fixed-width 2-to-1 datapath muxes.
- Used where a selected source crosses a pipeline stage boundary, e.g. writeback data or destination-register selection feeding a stalled stage.
- Provides a valid/ready handshake and a 2-entry skid buffer, so back-pressure never drops or duplicates a beat and in_ready is fully registered.

Parameters:
- WIDTH, 32, data bits per input channel.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, 2, select width; NUM_IN <= 2**SEL_W is required, otherwise elaboration fails via a generate-time error.

Ports:
- Clk  input  1  single clock, rising edge.
- Rst  input  1  reset; asynchronous, active-low.
- in_data  input  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- select  input  SEL_W  channel index, sampled with in_data.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat.
- out_data  output  WIDTH  selected data.
- out_sel  output  SEL_W  select value that produced out_data.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  downstream accepts.
- sel_err  output  1  sticky out-of-range select flag; see Optional Feature.
- sel_err_clr  input  1  clears sel_err.
- beat_cnt  output  16  accepted-beat counter, wraps modulo 2**16.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low.
- While Rst = 0: out_valid = 0, out_data = 0, out_sel = 0, in_ready = 0, sel_err = 0, beat_cnt = 0, both buffer entries empty.
- Release: in_ready rises on the first Clk edge after Rst deasserts.
- Handshake:
  - Input transfer when in_valid & in_ready at a rising edge.
  - Output transfer when out_valid & out_ready.
  - in_valid may not depend on in_ready.
- Selection: the captured word is in_data[select*WIDTH +: WIDTH]. If select >= NUM_IN, the captured word is all zeros and out_sel is the raw select value.
- Storage: main register M drives the outputs; skid register S is behind it. Buffer states and transitions:
  - EMPTY (M empty, S empty):
    - Input transfer loads M -> ONE.
  - ONE (M full, S empty):
    - Input and output transfer in the same cycle: M reloads, stay ONE.
    - Input transfer only: load S -> FULL.
    - Output transfer only -> EMPTY.
  - FULL (M full, S full):
    - in_ready = 0.
    - Output transfer moves S into M -> ONE.
- Latency: 1 cycle from input transfer to out_valid when M is empty. Throughput is 1 beat/cycle when out_ready stays high.
- Ordering: beats leave strictly in acceptance order; no loss or duplication.
- Registered ready: in_ready = !S_full, registered, with no combinational path from out_ready.
- Flow-control boundaries:
  - out_ready low with out_valid high: out_data/out_sel are held stable.
  - FULL state with in_valid high: no capture occurs.
- beat_cnt: increments by 1 per input transfer; 0xFFFF -> 0x0000.
- Reset mid-operation: both entries are discarded immediately (asynchronous); beats in flight are lost by design.

Optional Feature:
- Macro name: MUX_SEL_CHECK_EN.
- Defined:
  - An input transfer with select >= NUM_IN sets sel_err on the next edge.
  - sel_err holds until a cycle with sel_err_clr = 1.
  - Set takes priority over clear in the same cycle.
- Undefined:
  - sel_err is tied to 0 and sel_err_clr is ignored.
  - The zero-data rule for out-of-range select still applies.
  - No checking logic is synthesised.

Test Plan (WIDTH=5, NUM_IN=3, SEL_W=2):
- Reset: hold Rst = 0 for 3 cycles with in_valid = 1 -> all outputs 0, in_ready = 0; in_ready = 1 one edge after release.
- Streaming: channels {2:5'h1C, 1:5'h0A, 0:5'h03}, select 0,1,2 on consecutive cycles, out_ready = 1 -> out_data 03, 0A, 1C on cycles 1-3; beat_cnt = 3.
- Back-pressure:
  - Drop out_ready before the first beat and push 3 beats -> in_ready falls after the 2nd accept, out_data holds 03.
  - Raise out_ready -> 03, 0A, 1C delivered in order with no gaps.
- Out-of-range select: select = 3, data all ones ->
  - out_data = 0, out_sel = 3.
  - With MUX_SEL_CHECK_EN: sel_err = 1 until a sel_err_clr pulse, then 0.
  - Simultaneous bad select and clear -> sel_err = 1.
- Mid-operation reset: FULL state, assert Rst between edges -> out_valid drops immediately; after release no stale beat appears and beat_cnt = 0.
- Counter wrap: force 65536 accepted beats -> beat_cnt returns to 0x0000.
